pc_fetch_ctrl: RTL

//  Program-counter register and instruction-fetch sequencer for the single-cycle CPU.

---
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer.
// Holds the PC, fetches one instruction at a time over a req/ack handshake,
// keeps it for decode until released, then advances to PC+4 or a branch target.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        misalign_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    // Timeout limit as an 8-bit constant so it compares directly with the counter.
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        hold_release;

    // Decode is letting go of the current instruction this cycle.
    assign hold_release = (state_q == S_HOLD) && !stall_i;

    // Next-state and next-register computation; every register holds by default.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d       = imem_data_i;
                    instr_valid_d = 1'b1;
                    wait_cnt_d    = 8'd0;
                    state_d       = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == MAX_WAIT_C) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    // Branch targets are forced word-aligned; misalign_o flags the drop.
                    pc_d          = branch_i ? {branch_target_i[31:2], 2'b00} : pc_plus4_i;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_ERROR: begin
                // Sticky until reset; late acks are ignored.
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign imem_req_o    = (state_q == S_FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign misalign_o    = hold_release && branch_i && (branch_target_i[1:0] != 2'b00);
    assign fetch_err_o   = fetch_err_q;

endmodule
